// File: rtl/tb_sim_controller.sv
// Simulation controller: holds the harts in reset, enables fetch, watches for
// pass/fail/exit events, timeouts and hangs, then drains and reports a verdict.
module tb_sim_controller #(
  parameter int NUM_HARTS       = 2,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int MAX_CYCLES      = 0,
  parameter int HANG_CYCLES     = 1024,
  parameter int DRAIN_CYCLES    = 8,
  parameter int CNT_W           = 32,
  localparam int SRC_W          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                    core_clk,
  input  logic                    core_rst_n,
  output logic                    hart_rst_no,
  output logic [NUM_HARTS-1:0]    fetch_enable_o,
  input  logic [NUM_HARTS-1:0]    passed_i,
  input  logic [NUM_HARTS-1:0]    failed_i,
  input  logic [NUM_HARTS-1:0]    exit_valid_i,
  input  logic [32*NUM_HARTS-1:0] exit_value_i,
  input  logic [NUM_HARTS-1:0]    retire_i,
  output logic                    done_o,
  output logic [2:0]              status_o,
  output logic [31:0]             exit_value_o,
  output logic [SRC_W-1:0]        src_hart_o,
  output logic [CNT_W-1:0]        cycle_cnt_o
);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {
    ST_RUN = 3'd0, ST_PASS = 3'd1, ST_FAIL = 3'd2,
    ST_EXIT_ERR = 3'd3, ST_TIMEOUT = 3'd4, ST_HANG = 3'd5
  } status_t;

  state_t               state, next_state;
  logic [31:0]          phase_cnt;
  logic [31:0]          hang_cnt;
  logic [CNT_W-1:0]     cycle_cnt;
  logic [NUM_HARTS-1:0] term;
  logic [SRC_W-1:0]     last_hart;
  logic                 hart_rst_n;
  status_t              status;
  logic [31:0]          exit_value;
  logic [SRC_W-1:0]     src_hart;

  logic [NUM_HARTS-1:0] fail_ev, exit_err_ev, term_ev;
  logic                 finish;
  status_t              fin_status;
  logic [31:0]          fin_value;
  logic [SRC_W-1:0]     fin_src;

  // Lowest set index of a hart vector; used for tie-breaking between harts.
  function automatic logic [SRC_W-1:0] lowest(input logic [NUM_HARTS-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (v[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

  // Classify this cycle's events from harts that are still running.
  always_comb begin
    fail_ev     = failed_i & ~term;
    term_ev     = (passed_i | failed_i | exit_valid_i) & ~term;
    exit_err_ev = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      exit_err_ev[h] = exit_valid_i[h] && !term[h] && (exit_value_i[32*h +: 32] != 32'd0);
    end
  end

  // FSM state register.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= HOLD;
    else             state <= next_state;
  end

  // Next-state logic and the prioritised verdict for the RUN->DRAIN edge.
  always_comb begin
    next_state = state;
    finish     = 1'b0;
    fin_status = ST_RUN;
    fin_value  = 32'd0;
    fin_src    = '0;
    case (state)
      HOLD: if (phase_cnt == 32'(RST_HOLD_CYCLES - 1)) next_state = RUN;
      RUN: begin
        finish = 1'b1;
        if (|fail_ev) begin
          fin_status = ST_FAIL;
          fin_src    = lowest(fail_ev);
        end else if (|exit_err_ev) begin
          fin_status = ST_EXIT_ERR;
          fin_src    = lowest(exit_err_ev);
          fin_value  = exit_value_i[32*int'(fin_src) +: 32];
        end else if (MAX_CYCLES != 0 && cycle_cnt == CNT_W'(MAX_CYCLES)) begin
          fin_status = ST_TIMEOUT;
        end else if (HANG_CYCLES != 0 && hang_cnt == 32'(HANG_CYCLES)) begin
          fin_status = ST_HANG;
        end else if (&term) begin
          fin_status = ST_PASS;
          fin_src    = last_hart;
        end else begin
          finish = 1'b0;
        end
        if (finish) next_state = DRAIN;
      end
      DRAIN: if (phase_cnt == 32'(DRAIN_CYCLES - 1)) next_state = DONE;
      default: ;
    endcase
  end

  // Counters, termination tracking and the sticky verdict registers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      phase_cnt  <= '0;
      hang_cnt   <= '0;
      cycle_cnt  <= '0;
      term       <= '0;
      last_hart  <= '0;
      hart_rst_n <= 1'b0;
      status     <= ST_RUN;
      exit_value <= '0;
      src_hart   <= '0;
    end else begin
      if (next_state != state)                 phase_cnt <= '0;
      else if (state == HOLD || state == DRAIN) phase_cnt <= phase_cnt + 32'd1;
      if (state == HOLD && next_state == RUN) hart_rst_n <= 1'b1;
      if (state == RUN) begin
        term <= term | term_ev;
        if (|term_ev) last_hart <= lowest(term_ev);
        if (!finish && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (|(retire_i & ~term))        hang_cnt <= '0;
        else if (hang_cnt != '1)        hang_cnt <= hang_cnt + 32'd1;
        if (finish) begin
          status     <= fin_status;
          exit_value <= fin_value;
          src_hart   <= fin_src;
        end
      end
    end
  end

  assign hart_rst_no    = hart_rst_n;
  assign fetch_enable_o = (state == RUN) ? ~term : '0;
  assign done_o         = (state == DONE);
  assign status_o       = status;
  assign exit_value_o   = exit_value;
  assign src_hart_o     = src_hart;
  assign cycle_cnt_o    = cycle_cnt;

endmodule
